// File: rtl/nice_funnel.sv
// nice_funnel: round-robin N-to-1 valid/ready merger with source tag and one-entry output register.
// Define NICE_FUNNEL_PKT_EN for packet mode (a port keeps the grant until it sends in_last).
module nice_funnel #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    localparam int SRC_W  = $clog2(N_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        in_valid,
    input  logic [N_PORTS*DATA_W-1:0] in_data,
    input  logic [N_PORTS-1:0]        in_last,
    output logic [N_PORTS-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_last,
    input  logic                      out_ready
);
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   base;
    logic [SRC_W-1:0]   gnt;
    logic [SRC_W-1:0]   nxt;
    logic [N_PORTS-1:0] req;
    logic               gnt_vld;
    logic               load;
    logic               accept;
    logic               adv;
    int                 k;

    assign load     = !out_valid || out_ready;
    assign accept   = load && gnt_vld;
    assign in_ready = (accept && !rst) ? N_PORTS'(1) << gnt : '0;
    assign nxt      = (gnt == SRC_W'(N_PORTS - 1)) ? '0 : gnt + 1'b1;

`ifdef NICE_FUNNEL_PKT_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state;
    state_t           state_d;
    logic [SRC_W-1:0] lock_port;
    logic [SRC_W-1:0] lock_d;

    // while locked only the owning port may be granted, even if it is momentarily idle
    assign req  = (state == LOCKED) ? in_valid & (N_PORTS'(1) << lock_port) : in_valid;
    assign base = (state == LOCKED) ? lock_port : ptr;
    assign adv  = accept && in_last[gnt];

    always_comb begin
        state_d = state;
        lock_d  = lock_port;
        if (accept && state == IDLE && !in_last[gnt]) begin
            state_d = LOCKED;
            lock_d  = gnt;
        end else if (accept && state == LOCKED && in_last[gnt]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_port <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_d;
            lock_port <= lock_d;
            if (accept) out_last <= in_last[gnt];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^in_last;
    assign req         = in_valid;
    assign base        = ptr;
    assign adv         = accept;
    assign out_last    = 1'b1;
`endif

    // scan downward so the port closest to base after the wrap wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        k       = 0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            k = int'(base) + j;
            if (k >= N_PORTS) k = k - N_PORTS;
            if (req[k]) begin
                gnt_vld = 1'b1;
                gnt     = SRC_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (load) out_valid <= accept;
            if (accept) begin
                out_data <= in_data[int'(gnt)*DATA_W +: DATA_W];
                out_src  <= gnt;
            end
            if (adv) ptr <= nxt;
        end
    end
endmodule

// File: tb/tb_nice_funnel.sv
// tb_nice_funnel: randomized and directed checks of nice_funnel against a cycle-level reference model.
module tb_nice_funnel;
    localparam int N = 4;
    localparam int DW = 32;
`ifdef NICE_FUNNEL_PKT_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_last = '1;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_last;
    logic            out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_lock = 0;
    bit          m_ov = 0;
    logic [31:0] m_od = '0;
    int          m_os = 0;
    bit          m_ol = 0;
    int          last_g = -1;

    nice_funnel #(.N_PORTS(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pd(int i);
        return 32'hA000_0000 + i;
    endfunction

    function automatic int m_grant();
        if (m_ov && !out_ready) return -1;
        if (PKT && m_locked) return in_valid[m_lock] ? m_lock : -1;
        for (int j = 0; j < N; j++)
            if (in_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        g = m_grant();
        return (rst || g < 0) ? '0 : N'(1) << g;
    endfunction

    task automatic set_data(int p, logic [31:0] v);
        in_data[p*DW +: DW] = v;
    endtask

    task automatic tick();
        int g;
        g = rst ? -1 : m_grant();
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_od = '0; m_os = 0; m_ol = 0; m_ptr = 0; m_locked = 0;
        end else if (g >= 0) begin
            m_ov = 1;
            m_od = in_data[g*DW +: DW];
            m_os = g;
            m_ol = PKT ? in_last[g] : 1'b1;
            if (!PKT) m_ptr = (g + 1) % N;
            else if (m_locked) begin
                if (in_last[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
            end else if (in_last[g]) m_ptr = (g + 1) % N;
            else begin m_locked = 1; m_lock = g; end
        end else if (!m_ov || out_ready) m_ov = 0;
        last_g = g;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = '1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got %0d exp 0", out_src); end
        checks++; if (out_last !== !PKT) begin errors++; $display("FAIL reset_out_last got %b exp %b", out_last, !PKT); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready2 got %b exp 0000", in_ready); end
        in_valid = '0; rst = 0;
        tick();
    endtask

    task automatic test_single();
        in_valid = 4'b0100; in_last = '1; set_data(2, 32'hDEAD_BEEF); out_ready = 1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", in_ready); end
        tick();
        in_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", out_data); end
        checks++; if (out_src !== 2'd2) begin errors++; $display("FAIL single_src got %0d exp 2", out_src); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", out_last); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_after got %b exp 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        in_valid = 4'b1001; set_data(0, pd(0)); set_data(3, pd(3));
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3 got %b exp 1000", in_ready); end
        tick();
        in_valid = 4'b0001;
        #1;
        checks++; if (out_src !== 2'd3) begin errors++; $display("FAIL wrap_src3 got %0d exp 3", out_src); end
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b exp 0001", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_src !== 2'd0 || out_data !== pd(0)) begin errors++; $display("FAIL wrap_src0 got %0d/%h exp 0/%h", out_src, out_data, pd(0)); end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1; tick(); rst = 0;
        in_valid = '1; in_last = '1; out_ready = 1;
        for (int i = 0; i < N; i++) set_data(i, pd(i));
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first got %b exp 0001", in_ready); end
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(c % N) || out_data !== pd(c % N)) begin errors++; $display("FAIL rr_beat%0d got v%b src%0d %h exp v1 src%0d %h", c, out_valid, out_src, out_data, c % N, pd(c % N)); end
            checks++; if (in_ready !== 4'(1 << ((c + 1) % N))) begin errors++; $display("FAIL rr_ready%0d got %b exp %b", c, in_ready, 4'(1 << ((c + 1) % N))); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b exp 0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== pd(3)) begin errors++; $display("FAIL bp_hold%0d got v%b src%0d %h exp v1 src3 %h", c, out_valid, out_src, out_data, pd(3)); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release got %b exp 0001", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL bp_next got v%b src%0d exp v1 src0", out_valid, out_src); end
        tick(); tick();
    endtask

    task automatic test_packet();
        rst = 1; tick(); rst = 0;
        out_ready = 1; in_last = 4'b0001; set_data(0, pd(0));
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0011; set_data(1, 32'h1000_0000);
        for (int b = 0; b < 3; b++) begin
            in_last[1] = (b == 2);
            #1;
            checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL pkt_ready%0d got %b exp 0010", b, in_ready); end
            tick();
            checks++; if (out_src !== 2'd1 || out_last !== (b == 2) || out_data !== 32'h1000_0000 + b) begin errors++; $display("FAIL pkt_beat%0d got src%0d last%b %h exp src1 last%b %h", b, out_src, out_last, out_data, b == 2, 32'h1000_0000 + b); end
            set_data(1, 32'h1000_0000 + b + 1);
        end
        in_valid = 4'b0001;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL pkt_ready_p0 got %b exp 0001", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_src !== 2'd0 || out_last !== 1'b1) begin errors++; $display("FAIL pkt_p0 got src%0d last%b exp src0 last1", out_src, out_last); end
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1; tick(); rst = 0;
        out_ready = 1; in_valid = 4'b0010; in_last = 4'b0001; set_data(1, pd(1)); set_data(0, pd(0));
        tick();
        out_ready = 0; in_valid = 4'b0011; rst = 1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rmid_ready got %b exp 0000", in_ready); end
        tick();
        rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rmid_grant got %b exp 0001", in_ready); end
        tick();
        in_valid = 4'b0010;
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL rmid_src got v%b src%0d exp v1 src0", out_valid, out_src); end
        out_ready = 1; in_last = '1;
        tick();
        in_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && last_g != i)) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    set_data(i, $urandom);
                    in_last[i] = ($urandom_range(0, 2) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            #1;
            er = m_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, er); end
            checks++; if (out_valid !== m_ov || out_src !== 2'(m_os) || out_data !== m_od) begin errors++; $display("FAIL rnd_out c%0d got v%b src%0d %h exp v%b src%0d %h", c, out_valid, out_src, out_data, m_ov, m_os, m_od); end
            checks++; if (out_last !== (PKT ? m_ol : 1'b1)) begin errors++; $display("FAIL rnd_last c%0d got %b exp %b", c, out_last, PKT ? m_ol : 1'b1); end
            tick();
        end
        rst = 0; in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
`ifdef NICE_FUNNEL_PKT_EN
        test_packet();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
